// File: rtl/multistep_shift_coproc.sv
// Multi-bit-per-cycle shift coprocessor on the shared CPI bus.
// Claims OPCODE instructions and returns shift/rotate/bit-reverse/byte-swap results; outputs are wired-OR safe.
module multistep_shift_coproc #(
  parameter logic [3:0] OPCODE = 4'he,
  parameter int         STEP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpi_valid,
  output logic        cpi_ready,
  output logic        cpi_wait,
  input  logic [31:0] cpi_inst,
  input  logic [31:0] cpi_r1,
  input  logic [31:0] cpi_r2,
  output logic [31:0] cpi_data,
  output logic        cpi_drop
);

  // state | meaning
  // IDLE  | waiting for a claimed instruction; all outputs 0
  // SHIFT | stepping value by up to STEP bits per cycle; cpi_wait high
  // DONE  | result presented for one cycle with ready/drop/wait

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_bad_step
      $error("multistep_shift_coproc: STEP must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_SHR   = 3'd0;
  localparam logic [2:0] OP_ROR   = 3'd1;
  localparam logic [2:0] OP_ASHR  = 3'd2;
  localparam logic [2:0] OP_BREV  = 3'd3;
  localparam logic [2:0] OP_SHL   = 3'd4;
  localparam logic [2:0] OP_ROL   = 3'd5;
  localparam logic [2:0] OP_ASHL  = 3'd6;
  localparam logic [2:0] OP_BSWAP = 3'd7;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [5:0]  rem_q, rem_d;
  logic [2:0]  op_q, op_d;
  logic        ready_q, ready_d;
  logic        wait_q, wait_d;
  logic        drop_q, drop_d;
  logic [31:0] data_q, data_d;

  logic        claim;
  logic        use_imm;
  logic [2:0]  subop;
  logic [5:0]  raw_amt;
  logic [5:0]  eff_amt;
  logic [5:0]  step_amt;
  logic        unused_bits;

  assign unused_bits = ^{cpi_inst[23:6], cpi_r2[31:6]};

  function automatic logic [31:0] shift_by(input logic [2:0] op, input logic [31:0] v,
                                           input logic [5:0] s);
    logic [63:0] dbl;
    logic [63:0] dbl_l;
    logic [31:0] r;
    dbl   = {v, v};
    dbl_l = dbl << s;
    case (op)
      OP_SHR:  r = v >> s;
      OP_ROR:  r = 32'(dbl >> s);
      OP_ASHR: r = $signed(v) >>> s;
      OP_SHL:  r = v << s;
      OP_ROL:  r = dbl_l[63:32];
      OP_ASHL: r = v[0] ? ~((~v) << s) : (v << s);
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  assign use_imm = cpi_inst[27];
  assign subop   = cpi_inst[26:24];
  assign raw_amt = use_imm ? cpi_inst[5:0] : cpi_r2[5:0];
  assign claim   = cpi_valid && !ready_q && (cpi_inst[31:28] == OPCODE);

  // Rotates wrap at 32; linear shifts saturate at 32; single-pass subops need no stepping.
  always_comb begin
    eff_amt = 6'd0;
    case (subop)
      OP_ROR, OP_ROL:               eff_amt = {1'b0, raw_amt[4:0]};
      OP_SHR, OP_ASHR, OP_SHL, OP_ASHL: eff_amt = (raw_amt > 6'd32) ? 6'd32 : raw_amt;
      default:                      eff_amt = 6'd0;
    endcase
  end

  assign step_amt = (rem_q > STEP_W) ? STEP_W : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      value_q <= 32'd0;
      rem_q   <= 6'd0;
      op_q    <= 3'd0;
      ready_q <= 1'b0;
      wait_q  <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      wait_q  <= wait_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (claim) begin
          value_d = cpi_r1;
          op_d    = subop;
          rem_d   = eff_amt;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!cpi_valid) begin
          rem_d   = 6'd0;
          state_d = IDLE;
        end else if (rem_q != 6'd0) begin
          value_d = shift_by(op_q, value_q, step_amt);
          rem_d   = rem_q - step_amt;
        end else begin
          if (op_q == OP_BREV) begin
            value_d = bit_rev(value_q);
          end else if (op_q == OP_BSWAP) begin
            value_d = {value_q[7:0], value_q[15:8], value_q[23:16], value_q[31:24]};
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so the bus sees clean, glitch-free levels.
  always_comb begin
    ready_d = 1'b0;
    drop_d  = 1'b0;
    wait_d  = 1'b0;
    data_d  = 32'd0;
    if (state_d == DONE) begin
      ready_d = 1'b1;
      drop_d  = 1'b1;
      data_d  = value_d;
    end
    if (state_d != IDLE) begin
      wait_d = 1'b1;
    end
  end

  assign cpi_ready = ready_q;
  assign cpi_wait  = wait_q;
  assign cpi_drop  = drop_q;
  assign cpi_data  = data_q;

endmodule
